// File: rtl/fifo_pair_packer_if.sv
// rtl/fifo_pair_packer_if.sv - upstream FIFO pop port and packed beat output port of the pair packer
interface fifo_pair_packer_if #(
    parameter int DATA_W = 16
);
    logic                  fifo_empty_i;
    logic                  fifo_rd_en_o;
    logic [DATA_W-1:0]     fifo_rdata_i;
    logic                  flush_i;
    logic                  m_valid_o;
    logic                  m_ready_i;
    logic [2*DATA_W-1:0]   m_data_o;
    logic                  m_half_o;
    logic [15:0]           beat_cnt_o;

    modport master (
        input  fifo_empty_i,
        input  fifo_rdata_i,
        input  flush_i,
        input  m_ready_i,
        output fifo_rd_en_o,
        output m_valid_o,
        output m_data_o,
        output m_half_o,
        output beat_cnt_o
    );

    modport slave (
        output fifo_empty_i,
        output fifo_rdata_i,
        output flush_i,
        output m_ready_i,
        input  fifo_rd_en_o,
        input  m_valid_o,
        input  m_data_o,
        input  m_half_o,
        input  beat_cnt_o
    );
endinterface

// File: rtl/fifo_pair_packer.sv
// rtl/fifo_pair_packer.sv - pops words from a sync FIFO and packs pairs into double-width beats
module fifo_pair_packer #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    fifo_pair_packer_if.master bus
);
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_LO    = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          pend_q, pend_d;
    logic                flush_q, flush_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic                half_q, half_d;
    logic [15:0]         cnt_q, cnt_d;

    logic [2:0]          held;
    logic [2:0]          occ;
    logic                rd_en;
    logic                cap;
    logic                hs;
    logic                take_flush;
    logic                flush_act;

    always_comb begin
        held       = 3'd0;
        occ        = 3'd0;
        rd_en      = 1'b0;
        cap        = 1'b0;
        hs         = 1'b0;
        take_flush = 1'b0;
        flush_act  = 1'b0;
        pend_d     = pend_q;
        state_d    = state_q;
        flush_d    = flush_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        half_d     = half_q;
        cnt_d      = cnt_q;

        case (state_q)
            S_LO:    held = 3'd1;
            S_OUT:   held = 3'd2;
            default: held = 3'd0;
        endcase
        occ = held + {1'b0, pend_q};

        rd_en = !rst && !bus.fifo_empty_i && (state_q != S_OUT)
                && (occ < 3'd2) && !flush_q;
        // read data always lands exactly one cycle after its pop
        cap = (pend_q != 2'd0);
        hs  = (state_q == S_OUT) && bus.m_ready_i;

        // a pop issued in the flush cycle counts as pending data, so the
        // word it fetches is folded into the flushed beat instead of lost
        take_flush = bus.flush_i && (state_q != S_OUT)
                     && ((state_q == S_LO) || (pend_q != 2'd0) || rd_en);
        flush_act  = flush_q || take_flush;
        flush_d    = flush_act;

        pend_d = pend_q + {1'b0, rd_en} - {1'b0, cap};

        case (state_q)
            S_EMPTY: begin
                if (cap) begin
                    lo_d = bus.fifo_rdata_i;
                    if (flush_act && (pend_d == 2'd0)) begin
                        state_d = S_OUT;
                        half_d  = 1'b1;
                        hi_d    = '0;
                        flush_d = 1'b0;
                    end else begin
                        state_d = S_LO;
                    end
                end
            end
            S_LO: begin
                if (cap) begin
                    hi_d    = bus.fifo_rdata_i;
                    state_d = S_OUT;
                    half_d  = 1'b0;
                    flush_d = 1'b0;
                end else if (flush_act && (pend_d == 2'd0)) begin
                    state_d = S_OUT;
                    half_d  = 1'b1;
                    hi_d    = '0;
                    flush_d = 1'b0;
                end
            end
            S_OUT: begin
                flush_d = 1'b0;
                if (hs) begin
                    state_d = S_EMPTY;
                    half_d  = 1'b0;
                    lo_d    = '0;
                    hi_d    = '0;
                    cnt_d   = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            pend_q  <= 2'd0;
            flush_q <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            half_q  <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            flush_q <= flush_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            half_q  <= half_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.fifo_rd_en_o = rd_en;
    assign bus.m_valid_o    = (state_q == S_OUT);
    assign bus.m_data_o     = {hi_q, lo_q};
    assign bus.m_half_o     = half_q;
    assign bus.beat_cnt_o   = cnt_q;
endmodule

// File: tb/tb_fifo_pair_packer.sv
// tb/tb_fifo_pair_packer.sv - directed bench with beat scoreboard and per-cycle invariant checks
module tb_fifo_pair_packer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    fifo_pair_packer_if #(.DATA_W(16)) bus ();

    fifo_pair_packer #(.DATA_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    // expectations written by the stimulus process, consumed by the checker
    logic [31:0] exp_data [0:31];
    logic        exp_half [0:31];
    int          exp_wr = 0;
    int          exp_rd = 0;

    logic        lat_arm    = 1'b0;
    logic        do_preload = 1'b0;
    logic        done       = 1'b0;

    int          n_chk = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- checker ----------------
    int          cyc = 0;
    int          lat_n = -1;
    logic        rst_prev = 1'b0;
    logic        prev_stall = 1'b0;
    logic        prev_hs = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_half = 1'b0;
    logic        pre_phase = 1'b0;
    logic [15:0] model_cnt = 16'd0;

    always @(negedge clk) begin
        cyc++;
        if (pre_phase) begin
            release dut.cnt_q;
            model_cnt = 16'hFFFF;
            pre_phase = 1'b0;
        end

        if (rst_prev) begin
            chk("rst_valid", {31'd0, bus.m_valid_o}, 32'd0);
            chk("rst_half",  {31'd0, bus.m_half_o}, 32'd0);
            chk("rst_data",  bus.m_data_o, 32'd0);
            chk("rst_cnt",   {16'd0, bus.beat_cnt_o}, 32'd0);
        end else begin
            if (prev_stall) begin
                chk("stall_valid", {31'd0, bus.m_valid_o}, 32'd1);
                chk("stall_data",  bus.m_data_o, prev_data);
                chk("stall_half",  {31'd0, bus.m_half_o}, {31'd0, prev_half});
            end
            if (prev_hs)
                chk("valid_drop", {31'd0, bus.m_valid_o}, 32'd0);
            chk("beat_cnt", {16'd0, bus.beat_cnt_o}, {16'd0, model_cnt});
        end

        if (rst)
            chk("rd_en_in_rst", {31'd0, bus.fifo_rd_en_o}, 32'd0);
        chk("rd_en_empty", {31'd0, bus.fifo_rd_en_o & bus.fifo_empty_i}, 32'd0);
        if (bus.m_valid_o)
            chk("rd_en_in_out", {31'd0, bus.fifo_rd_en_o}, 32'd0);

        // pops at N and N+1 must give a valid beat from N+3
        if (!lat_arm) begin
            lat_n = -1;
        end else if (lat_n < 0) begin
            if (bus.fifo_rd_en_o) lat_n = cyc;
        end else if (cyc - lat_n == 1) begin
            chk("lat_pop2", {31'd0, bus.fifo_rd_en_o}, 32'd1);
        end else if (cyc - lat_n == 2) begin
            chk("lat_not_yet", {31'd0, bus.m_valid_o}, 32'd0);
        end else if (cyc - lat_n == 3) begin
            chk("lat_valid", {31'd0, bus.m_valid_o}, 32'd1);
        end

        if (!rst && bus.m_valid_o && bus.m_ready_i) begin
            if (exp_rd >= exp_wr) begin
                chk("unexpected_beat", bus.m_data_o, 32'hxxxx_xxxx);
            end else begin
                chk("beat_data", bus.m_data_o, exp_data[exp_rd]);
                chk("beat_half", {31'd0, bus.m_half_o}, {31'd0, exp_half[exp_rd]});
                exp_rd++;
            end
            model_cnt = model_cnt + 16'd1;
        end

        prev_stall = !rst && bus.m_valid_o && !bus.m_ready_i;
        prev_hs    = !rst && bus.m_valid_o && bus.m_ready_i;
        prev_data  = bus.m_data_o;
        prev_half  = bus.m_half_o;
        rst_prev   = rst;
        if (rst) model_cnt = 16'd0;

        // held across an idle edge so the counter register itself takes the value
        if (do_preload) begin
            force dut.cnt_q = 16'hFFFF;
            pre_phase = 1'b1;
        end

        if (done) begin
            chk("all_beats_seen", exp_rd, exp_wr);
            chk("final_cnt", {16'd0, bus.beat_cnt_o}, 32'd0);
            $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
            $finish;
        end
    end

    // ---------------- stimulus / upstream FIFO ----------------
    logic [15:0] fifo_q[$];

    task automatic step();
        logic p;
        @(negedge clk);
        p = bus.fifo_rd_en_o;
        @(posedge clk);
        #1;
        if (p && fifo_q.size() > 0) bus.fifo_rdata_i = fifo_q.pop_front();
        bus.fifo_empty_i = (fifo_q.size() == 0);
    endtask

    task automatic push(input logic [15:0] w);
        fifo_q.push_back(w);
        bus.fifo_empty_i = 1'b0;
    endtask

    task automatic expect_beat(input logic [31:0] d, input logic h);
        exp_data[exp_wr] = d;
        exp_half[exp_wr] = h;
        exp_wr++;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_rd != exp_wr; i++) step();
        repeat (3) step();
    endtask

    initial begin
        bus.fifo_empty_i = 1'b1;
        bus.fifo_rdata_i = 16'h0000;
        bus.flush_i      = 1'b0;
        bus.m_ready_i    = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        // single pair with ready held high
        lat_arm = 1'b1;
        expect_beat(32'h2222_1111, 1'b0);
        push(16'h1111);
        push(16'h2222);
        drain();
        lat_arm = 1'b0;

        // six words behind a downstream stall; a flush during the stall is ignored
        expect_beat(32'h0002_0001, 1'b0);
        expect_beat(32'h0004_0003, 1'b0);
        expect_beat(32'h0006_0005, 1'b0);
        bus.m_ready_i = 1'b0;
        for (int i = 1; i <= 6; i++) push(16'(i));
        repeat (3) step();
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        step();
        bus.m_ready_i = 1'b1;
        drain();

        // flush while idle produces nothing
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        repeat (6) step();

        // lone word flushed out as a half beat
        expect_beat(32'h0000_ABCD, 1'b1);
        push(16'hABCD);
        repeat (3) step();
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        drain();

        // FIFO runs dry mid-pair, then refills
        expect_beat(32'h5678_1234, 1'b0);
        push(16'h1234);
        repeat (8) step();
        push(16'h5678);
        drain();

        // flush together with the first pop stops the second pop
        expect_beat(32'h0000_5555, 1'b1);
        push(16'h5555);
        push(16'h6666);
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        drain();
        repeat (4) step();
        expect_beat(32'h7777_6666, 1'b0);
        push(16'h7777);
        drain();

        // reset with one word held and one in flight
        push(16'h7777);
        push(16'h8888);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        expect_beat(32'h0B0B_0A0A, 1'b0);
        push(16'h0A0A);
        push(16'h0B0B);
        drain();

        // counter wrap
        do_preload = 1'b1;
        step();
        do_preload = 1'b0;
        repeat (2) step();
        expect_beat(32'hBEEF_C0DE, 1'b0);
        push(16'hC0DE);
        push(16'hBEEF);
        drain();

        done = 1'b1;
    end
endmodule

// File: doc/fifo_pair_packer.md
FIFO_PAIR_PACKER -- requirements
Module: fifo_pair_packer

Interface
REQ-001 Parameter: DATA_W, default 16, width of one FIFO word; output beat width is 2*DATA_W.
REQ-002 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  in  1  reset, synchronous, active-high.
REQ-004 Port: fifo_empty_i  in  1  upstream sync FIFO empty flag.
REQ-005 Port: fifo_rd_en_o  out  1  pop request to upstream FIFO.
REQ-006 Port: fifo_rdata_i  in  DATA_W  FIFO read data, valid the cycle after a pop.
REQ-007 Port: flush_i  in  1  single-cycle request to emit a pending half-filled beat.
REQ-008 Port: m_valid_o  out  1  output beat valid.
REQ-009 Port: m_ready_i  in  1  downstream accept.
REQ-010 Port: m_data_o  out  2*DATA_W  packed beat; first popped word in [DATA_W-1:0], second in upper half.
REQ-011 Port: m_half_o  out  1  beat carries only the low word; upper half is zero.
REQ-012 Port: beat_cnt_o  out  16  count of accepted output beats.

Function
REQ-013 States SHALL be S_EMPTY (no word held), S_LO (low word held), S_OUT (beat presented); internal pend counter (0..2) tracks pops whose data has not yet arrived.
REQ-014 Occupancy = held words + pend; fifo_rd_en_o SHALL be high iff !rst && !fifo_empty_i && state != S_OUT && occupancy < 2 && flush latch clear.
REQ-015 fifo_rd_en_o SHALL never assert while fifo_empty_i is high.
REQ-016 Each pop increments pend; data on fifo_rdata_i one cycle later is captured into the next free half and pend decrements; simultaneous pop and capture leaves pend unchanged.
REQ-017 Capturing the second word SHALL move S_LO -> S_OUT; m_valid_o rises the cycle after the second word is on fifo_rdata_i (pops in cycles N, N+1 -> m_valid_o high from N+3).
REQ-018 In S_OUT m_data_o, m_half_o SHALL be held stable until m_valid_o && m_ready_i; no pops issued in S_OUT.
REQ-019 On handshake: state -> S_EMPTY, m_valid_o low next cycle, m_half_o cleared, beat_cnt_o += 1 (0xFFFF wraps to 0x0000).
REQ-020 m_ready_i may be high before m_valid_o; no combinational path from m_ready_i to any output.
REQ-021 flush_i in S_LO with pend == 0: next cycle S_OUT, m_data_o = {0, lo}, m_half_o = 1.
REQ-022 flush_i with pend > 0: latch flush, stop popping; when pending data lands, pair complete -> normal full beat (m_half_o = 0), single word -> half beat; latch clears on entry to S_OUT.
REQ-023 flush_i in S_EMPTY with pend == 0, or in S_OUT: ignored, no latch.
REQ-024 fifo_empty_i rising mid-pair SHALL leave state in S_LO indefinitely; popping resumes when empty drops.

Reset
REQ-025 While rst is high at a clk edge: state S_EMPTY, pend 0, flush latch 0, m_valid_o 0, m_half_o 0, m_data_o 0, beat_cnt_o 0; fifo_rd_en_o low in every cycle rst is high.
REQ-026 Reset mid-operation SHALL discard held words and in-flight read data; first cycle after rst low behaves as fresh S_EMPTY.

Verification
REQ-027 FIFO holds 0x1111, 0x2222; m_ready_i=1 -> pops in cycles N, N+1, beat 0x2222_1111, m_half_o=0, m_valid_o high at N+3 for one cycle, beat_cnt_o=1.
REQ-028 Six words 0x0001..0x0006, m_ready_i low 5 cycles then high -> first beat 0x0002_0001 held stable, no pops during stall, then 0x0004_0003, 0x0006_0005 in order, beat_cnt_o=3.
REQ-029 One word 0xABCD then empty, flush_i pulse after capture -> beat 0x0000_ABCD, m_half_o=1.
REQ-030 flush_i in same cycle as first pop of 0x5555 (second word 0x6666 present) -> no second pop, half beat 0x0000_5555; next beat later 0x0000_6666 only after new flush or following word.
REQ-031 rst asserted with one word held and one pop in flight -> all outputs 0 next cycle, subsequent words 0x0A0A, 0x0B0B pack as 0x0B0B_0A0A.
REQ-032 Preload beat_cnt_o to 0xFFFF via 65535 handshakes (or force) then one more -> beat_cnt_o=0x0000.
